// File: rtl/musb_arb_pkg.sv
// Shared constants for the two-master memory arbiter: FSM state encoding and port indices.
package musb_arb_pkg;

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] GRANT_M0 = 2'd1;
   localparam logic [1:0] GRANT_M1 = 2'd2;
   localparam logic [1:0] RELEASE  = 2'd3;

   localparam logic PORT_M0 = 1'b0;
   localparam logic PORT_M1 = 1'b1;

endpackage

// File: rtl/musb_arb_select.sv
// Combinational winner selection between the two masters.
// Tie policy: round-robin when MUSB_ARB_ROUND_ROBIN_EN is defined, otherwise m1 always wins.
module musb_arb_select
   import musb_arb_pkg::*;
(
   input  logic m0_enable,
   input  logic m1_enable,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant_id
);

   // NOTE: every output gets a default first so no path through the block infers a latch.
   always_comb begin
      grant_valid = m0_enable | m1_enable;
      grant_id    = PORT_M0;
      if (m0_enable && m1_enable) begin
`ifdef MUSB_ARB_ROUND_ROBIN_EN
         grant_id = ~last_grant;
`else
         grant_id = PORT_M1;
`endif
      end else if (m1_enable) begin
         grant_id = PORT_M1;
      end
   end

`ifndef MUSB_ARB_ROUND_ROBIN_EN
   // Fixed priority ignores the grant history.
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/musb_mem_arbiter.sv
// Two-master, one-slave memory arbiter: holds one master on the shared port until the slave
// completes, acks that master only, inserts one RELEASE bubble, then re-arbitrates.
module musb_mem_arbiter
   import musb_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA       = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] m0_address,
   input  logic [DATA-1:0]       m0_data_i,
   input  logic                  m0_wr,
   input  logic [DATA/8-1:0]     m0_byte_sel,
   input  logic                  m0_enable,
   output logic                  m0_ready,
   output logic [DATA-1:0]       m0_data_o,
   input  logic [ADDR_WIDTH-1:0] m1_address,
   input  logic [DATA-1:0]       m1_data_i,
   input  logic                  m1_wr,
   input  logic [DATA/8-1:0]     m1_byte_sel,
   input  logic                  m1_enable,
   output logic                  m1_ready,
   output logic [DATA-1:0]       m1_data_o,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA-1:0]       mem_data_o,
   output logic                  mem_wr,
   output logic [DATA/8-1:0]     mem_byte_sel,
   output logic                  mem_enable,
   input  logic                  mem_ready,
   input  logic [DATA-1:0]       mem_data_i
);

   logic [1:0] state_q, state_d;
   logic       last_grant_q, last_grant_d;
   logic       grant_valid;
   logic       grant_id;

   musb_arb_select u_select (
      .m0_enable   (m0_enable),
      .m1_enable   (m1_enable),
      .last_grant  (last_grant_q),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= PORT_M1;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   // The grant is only decided in IDLE; a dropped enable aborts without an ack.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               state_d      = (grant_id == PORT_M1) ? GRANT_M1 : GRANT_M0;
               last_grant_d = grant_id;
            end
         end
         GRANT_M0: begin
            if (!m0_enable)     state_d = IDLE;
            else if (mem_ready) state_d = RELEASE;
         end
         GRANT_M1: begin
            if (!m1_enable)     state_d = IDLE;
            else if (mem_ready) state_d = RELEASE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request and response muxes; everything idles at zero outside a grant.
   always_comb begin
      mem_enable   = 1'b0;
      mem_address  = '0;
      mem_data_o   = '0;
      mem_wr       = 1'b0;
      mem_byte_sel = '0;
      m0_ready     = 1'b0;
      m1_ready     = 1'b0;
      m0_data_o    = '0;
      m1_data_o    = '0;
      case (state_q)
         GRANT_M0: begin
            mem_enable   = m0_enable;
            mem_address  = m0_address;
            mem_data_o   = m0_data_i;
            mem_wr       = m0_wr;
            mem_byte_sel = m0_byte_sel;
            m0_ready     = m0_enable & mem_ready;
            if (m0_ready) m0_data_o = mem_data_i;
         end
         GRANT_M1: begin
            mem_enable   = m1_enable;
            mem_address  = m1_address;
            mem_data_o   = m1_data_i;
            mem_wr       = m1_wr;
            mem_byte_sel = m1_byte_sel;
            m1_ready     = m1_enable & mem_ready;
            if (m1_ready) m1_data_o = mem_data_i;
         end
         default: ;
      endcase
   end

endmodule
